// File: rtl/da_mac_serial.sv
// Bit-serial distributed-arithmetic MAC: C = sum A[k]*B[k], activations consumed LSB first.
// Build option DA_SAT_EN: saturate the scaled result to OUT_WIDTH instead of wrapping.
module da_mac_serial #(
   parameter int DATA_WIDTH_A = 16,
   parameter int DATA_WIDTH_B = 16,
   parameter int K            = 9,
   parameter int ACC_W        = DATA_WIDTH_A + DATA_WIDTH_B + $clog2(K),
   parameter int OUT_WIDTH    = ACC_W,
   parameter int OUT_SHIFT    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [K*DATA_WIDTH_A-1:0] A_in,
   input  logic [K*DATA_WIDTH_B-1:0] B_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH-1:0]      C_out,
   output logic                      busy
);
   localparam int NG = (K + 3) / 4;
   localparam int NT = NG * 4;
   localparam int PW = DATA_WIDTH_B + $clog2(K) + 1;
   localparam int JW = $clog2(DATA_WIDTH_A + 1);
   localparam logic [JW-1:0] J_LAST = JW'(DATA_WIDTH_A - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
   state_t state_r, state_next_s;

   logic [K*DATA_WIDTH_A-1:0]       a_r;
   logic [K*DATA_WIDTH_B-1:0]       b_r;
   logic [JW-1:0]                   j_r, pidx_r;
   logic signed [PW-1:0]            p_r, p_sum_s, grp_s;
   logic signed [ACC_W-1:0]         acc_r, acc_next_s, term_s, scaled_s;
   logic                            tap_a_s [NT];
   logic signed [DATA_WIDTH_B-1:0]  tap_b_s [NT];
   logic                            accept_s, acc_en_s;
   logic                            in_ready_r, out_valid_r, busy_r;
   logic [OUT_WIDTH-1:0]            c_out_r;

   function automatic logic [OUT_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef DA_SAT_EN
      localparam int XW = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
      logic signed [XW-1:0] x;
      logic signed [XW-1:0] hi;
      logic signed [XW-1:0] lo;
      x  = XW'(v);
      hi = XW'((XW'(1'b1) << (OUT_WIDTH - 1)) - XW'(1'b1));
      lo = XW'(~hi);
      if (x > hi) return hi[OUT_WIDTH-1:0];
      else if (x < lo) return lo[OUT_WIDTH-1:0];
      else return x[OUT_WIDTH-1:0];
`else
      return OUT_WIDTH'(v);
`endif
   endfunction

   // Taps beyond K pad the last group with zero weights and clear activation bits.
   for (genvar k = 0; k < NT; k++) begin : g_tap
      if (k < K) begin : g_real
         assign tap_a_s[k] = a_r[k*DATA_WIDTH_A];
         assign tap_b_s[k] = b_r[k*DATA_WIDTH_B +: DATA_WIDTH_B];
      end else begin : g_pad
         assign tap_a_s[k] = 1'b0;
         assign tap_b_s[k] = '0;
      end
   end

   // Partial sum for the current activation bit, built from 4-tap groups.
   always_comb begin
      p_sum_s = '0;
      grp_s   = '0;
      for (int g = 0; g < NG; g++) begin
         grp_s = '0;
         for (int t = 0; t < 4; t++) begin
            if (tap_a_s[g*4+t]) grp_s = grp_s + PW'(tap_b_s[g*4+t]);
            else                grp_s = grp_s;
         end
         p_sum_s = p_sum_s + grp_s;
      end
   end

   // Accumulator update: the sign bit of the activation carries negative weight.
   always_comb begin
      term_s = ACC_W'(p_r) <<< pidx_r;
      if (pidx_r == J_LAST) acc_next_s = acc_r - term_s;
      else                  acc_next_s = acc_r + term_s;
      scaled_s = acc_next_s >>> OUT_SHIFT;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_next_s;
   end

   // Sequencer: next state, accept strobe and accumulator enable.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      acc_en_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next_s = RUN;
               accept_s     = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            acc_en_s = (j_r != '0);
            if (j_r == J_LAST) state_next_s = DRAIN;
            else               state_next_s = RUN;
         end
         DRAIN: begin
            acc_en_s     = 1'b1;
            state_next_s = DONE;
         end
         DONE: begin
            if (out_ready) state_next_s = IDLE;
            else           state_next_s = DONE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Operand latch, bit sequencing and the registered partial-sum stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r    <= '0;
         b_r    <= '0;
         j_r    <= '0;
         pidx_r <= '0;
         p_r    <= '0;
      end else if (accept_s) begin
         a_r <= A_in;
         b_r <= B_in;
         j_r <= '0;
      end else if (state_r == RUN) begin
         a_r    <= a_r >> 1;
         j_r    <= j_r + JW'(1'b1);
         p_r    <= p_sum_s;
         pidx_r <= j_r;
      end else begin
         a_r <= a_r;
      end
   end

   // Accumulator, result register and handshake flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r       <= '0;
         c_out_r     <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         if (accept_s)      acc_r <= '0;
         else if (acc_en_s) acc_r <= acc_next_s;
         else               acc_r <= acc_r;
         if (state_r == DRAIN) begin
            c_out_r     <= reduce(scaled_s);
            out_valid_r <= 1'b1;
         end else if (state_r == DONE && out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         in_ready_r <= (state_next_s == IDLE);
         busy_r     <= (state_next_s != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign C_out     = c_out_r;
   assign busy      = busy_r;
endmodule
